// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Types and helpers for the pipeline hazard unit:
//   hazard_state_t - wrong-path fetch tracking state
//   load_use()     - load-use dependency between execute and decode
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic {
    HZ_IDLE    = 1'b0,
    HZ_DISCARD = 1'b1
  } hazard_state_t;

  // A load in execute whose destination feeds either decode source.
  // x0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic load_use(
    input logic             e_memread,
    input logic [REG_W-1:0] e_rd,
    input logic [REG_W-1:0] d_rs1,
    input logic [REG_W-1:0] d_rs2
  );
    return e_memread && (e_rd != '0) && ((e_rd == d_rs1) || (e_rd == d_rs2));
  endfunction

endpackage : hazard_pkg

// File: rtl/pipes.sv
// ---------------------------------------------------------------------------
// pipes
// Pipeline-register control types shared by the hazard unit and the
// pipeline registers it drives. Each struct carries one enable per
// inter-stage register: fd (fetch/decode), de (decode/execute),
// em (execute/memory) and mw (memory/writeback).
// ---------------------------------------------------------------------------
package pipes;

  typedef struct packed {
    logic fd;
    logic de;
    logic em;
    logic mw;
  } regstall_en_t;

  typedef struct packed {
    logic fd;
    logic de;
    logic em;
    logic mw;
  } regflush_en_t;

endpackage : pipes

// File: rtl/md_occupancy.sv
// ---------------------------------------------------------------------------
// md_occupancy
// Counts how long a multi-cycle mul/div instruction has sat in execute and
// requests a stall until its final cycle.
// Ports:
//   clk        - clock
//   reset      - asynchronous, active-high reset
//   e_md_i     - execute-stage instruction is a valid mul/div
//   d_wait_i   - memory stage is stalled (freezes the count)
//   md_stall_o - mul/div must keep holding execute this cycle
// ---------------------------------------------------------------------------
module md_occupancy
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic e_md_i,
  input  logic d_wait_i,
  output logic md_stall_o
);

  localparam int unsigned CW = $clog2(MD_LAT) + 1;
  localparam logic [CW-1:0] LAST = CW'(MD_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The final cycle (cnt == LAST) is not a stall: the instruction leaves
  // execute at the end of it. With MD_LAT = 1 this is always the case.
  assign md_stall_o = e_md_i && (cnt_q != LAST);

  // NOTE: always_comb assigns a default first so every path writes cnt_d
  // and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!e_md_i) begin
      cnt_d = '0;
    end else if (!d_wait_i) begin
      if (md_stall_o) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        // Leaving edge: the next mul/div starts a fresh window.
        cnt_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : md_occupancy

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Central stall/flush controller for the 5-stage pipeline. Resolves memory
// waits, mul/div occupancy, execute redirects, load-use dependencies and
// fetch waits into per-register stall/flush enables and a PC stall, and
// drops a wrong-path fetch that is still in flight when a redirect fires.
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   i_wait              - instruction fetch outstanding
//   d_wait              - memory-stage data access outstanding
//   d_rs1, d_rs2        - decode-stage source registers
//   e_rd                - execute-stage destination register
//   e_memread           - execute-stage instruction is a load
//   e_md                - execute-stage instruction is a valid mul/div
//   e_redirect          - execute resolved a mispredicted branch/jump
//   pc_stall            - hold the PC
//   stall               - hold pipeline registers
//   flush               - insert bubbles into pipeline registers
//   md_busy             - mul/div is holding execute
// ---------------------------------------------------------------------------
module hazard_unit
  import hazard_pkg::*;
  import pipes::*;
#(
  parameter int unsigned MD_LAT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wait,
  input  logic             d_wait,
  input  logic [REG_W-1:0] d_rs1,
  input  logic [REG_W-1:0] d_rs2,
  input  logic [REG_W-1:0] e_rd,
  input  logic             e_memread,
  input  logic             e_md,
  input  logic             e_redirect,
  output logic             pc_stall,
  output regstall_en_t     stall,
  output regflush_en_t     flush,
  output logic             md_busy
);

  hazard_state_t state_q, state_d;
  logic          md_stall;
  logic          lu;

  md_occupancy #(
    .MD_LAT(MD_LAT)
  ) u_md_occupancy (
    .clk       (clk),
    .reset     (reset),
    .e_md_i    (e_md),
    .d_wait_i  (d_wait),
    .md_stall_o(md_stall)
  );

  assign lu = load_use(e_memread, e_rd, d_rs1, d_rs2);

  // Wrong-path tracking. A redirect only takes effect when execute is not
  // held; if the fetch for the old path is still outstanding, its data must
  // be dropped when it finally returns.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HZ_IDLE: begin
        if (e_redirect && i_wait && !d_wait && !md_stall) begin
          state_d = HZ_DISCARD;
        end
      end
      HZ_DISCARD: begin
        // A new redirect keeps us here; otherwise leave once the stale
        // fetch returns on an unstalled cycle.
        if (!i_wait && !d_wait && !md_stall && !e_redirect) begin
          state_d = HZ_IDLE;
        end
      end
      default: state_d = HZ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority mux: the first matching condition drives every output.
  always_comb begin
    pc_stall = 1'b0;
    stall    = '0;
    flush    = '0;
    md_busy  = md_stall;
    if (reset) begin
      pc_stall = 1'b1;
      flush    = '1;
      md_busy  = 1'b0;
    end else if (d_wait) begin
      // Execute is frozen, so a redirect seen now re-presents later.
      pc_stall = 1'b1;
      stall.fd = 1'b1;
      stall.de = 1'b1;
      stall.em = 1'b1;
      flush.mw = 1'b1;
    end else if (md_stall) begin
      pc_stall = 1'b1;
      stall.fd = 1'b1;
      stall.de = 1'b1;
      flush.em = 1'b1;
    end else if (e_redirect) begin
      flush.fd = 1'b1;
      flush.de = 1'b1;
    end else if (lu) begin
      pc_stall = 1'b1;
      stall.fd = 1'b1;
      flush.de = 1'b1;
    end else if (i_wait) begin
      pc_stall = 1'b1;
      flush.fd = 1'b1;
    end else if (state_q == HZ_DISCARD) begin
      // The returning instruction belongs to the abandoned path.
      flush.fd = 1'b1;
    end
  end

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import pipes::*;

  localparam int unsigned MD_LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_wait, d_wait, e_memread, e_md, e_redirect;
  logic [4:0]   d_rs1, d_rs2, e_rd;
  logic         pc_stall, md_busy;
  regstall_en_t stall;
  regflush_en_t flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MD_LAT(MD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_wait    (i_wait),
    .d_wait    (d_wait),
    .d_rs1     (d_rs1),
    .d_rs2     (d_rs2),
    .e_rd      (e_rd),
    .e_memread (e_memread),
    .e_md      (e_md),
    .e_redirect(e_redirect),
    .pc_stall  (pc_stall),
    .stall     (stall),
    .flush     (flush),
    .md_busy   (md_busy)
  );

  // Expected outputs packed as {pc_stall, stall[fd,de,em,mw], flush[fd,de,em,mw], md_busy}.
  typedef struct packed {
    logic       i_wait;
    logic       d_wait;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memread;
    logic       md;
    logic       redirect;
    logic [9:0] exp;
  } vec_t;

  localparam logic [9:0] O_NONE  = 10'b0_0000_0000_0;
  localparam logic [9:0] O_LU    = 10'b1_1000_0100_0;
  localparam logic [9:0] O_IWAIT = 10'b1_0000_1000_0;
  localparam logic [9:0] O_DWAIT = 10'b1_1110_0001_0;
  localparam logic [9:0] O_DW_MD = 10'b1_1110_0001_1;
  localparam logic [9:0] O_REDIR = 10'b0_0000_1100_0;
  localparam logic [9:0] O_MD    = 10'b1_1100_0010_1;
  localparam logic [9:0] O_DISC  = 10'b0_0000_1000_0;
  localparam logic [9:0] O_RESET = 10'b1_0000_1111_0;

  function automatic logic [9:0] outs();
    return {pc_stall, stall, flush, md_busy};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic iw, input logic dw, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                       input logic md, input logic rdr);
    i_wait = iw; d_wait = dw; d_rs1 = rs1; d_rs2 = rs2;
    e_rd = rd; e_memread = mr; e_md = md; e_redirect = rdr;
  endtask

  // Apply inputs just after the falling edge; sample 1 time unit later,
  // well away from the rising edge that updates state.
  task automatic step(input string name, input logic iw, input logic dw, input logic md,
                      input logic rdr, input logic [9:0] exp);
    @(negedge clk);
    drive(iw, dw, 5'd0, 5'd0, 5'd0, 1'b0, md, rdr);
    #1;
    check(name, outs(), exp);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[15];

  initial begin
    // i_wait d_wait rs1 rs2 rd memread md redirect expected
    vecs[0]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_NONE};
    vecs[1]  = '{0, 0, 5'd0, 5'd5, 5'd5, 1, 0, 0, O_LU};
    vecs[2]  = '{0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, O_NONE};
    vecs[3]  = '{0, 0, 5'd7, 5'd2, 5'd7, 1, 0, 0, O_LU};
    vecs[4]  = '{0, 0, 5'd3, 5'd4, 5'd7, 1, 0, 0, O_NONE};
    vecs[5]  = '{0, 0, 5'd0, 5'd5, 5'd5, 0, 0, 0, O_NONE};
    vecs[6]  = '{1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_IWAIT};
    vecs[7]  = '{0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, O_DWAIT};
    vecs[8]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, O_REDIR};
    vecs[9]  = '{0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_MD};
    vecs[10] = '{1, 0, 5'd9, 5'd0, 5'd9, 1, 1, 1, O_MD};
    vecs[11] = '{0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, O_DW_MD};
    vecs[12] = '{1, 0, 5'd6, 5'd0, 5'd6, 1, 0, 0, O_LU};
    vecs[13] = '{0, 0, 5'd6, 5'd0, 5'd6, 1, 0, 1, O_REDIR};
    vecs[14] = '{1, 1, 5'd6, 5'd0, 5'd6, 1, 0, 1, O_DWAIT};

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_outputs", outs(), O_RESET);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle priority table, each vector isolated by an idle cycle
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].i_wait, vecs[i].d_wait, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].memread, vecs[i].md, vecs[i].redirect);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      idle_cycle();
    end

    // Priority vector must not have entered DISCARD
    step("prio_state_idle_a", 1, 1, 0, 1, O_DWAIT);
    step("prio_state_idle_b", 0, 0, 0, 0, O_NONE);

    // mul/div residency and back-to-back window
    for (int c = 0; c < 8; c++)
      step($sformatf("md_b2b_c%0d", c + 1), 0, 0, 1, 0, ((c % 4) == 3) ? O_NONE : O_MD);
    idle_cycle();

    // d_wait pulse on cycle 2 extends the window by one
    step("md_dw_c1", 0, 0, 1, 0, O_MD);
    step("md_dw_c2", 0, 1, 1, 0, O_DW_MD);
    step("md_dw_c3", 0, 0, 1, 0, O_MD);
    step("md_dw_c4", 0, 0, 1, 0, O_MD);
    step("md_dw_c5", 0, 0, 1, 0, O_NONE);
    idle_cycle();

    // d_wait during the final cycle: count holds, md_busy stays low
    step("md_last_c1", 0, 0, 1, 0, O_MD);
    step("md_last_c2", 0, 0, 1, 0, O_MD);
    step("md_last_c3", 0, 0, 1, 0, O_MD);
    step("md_last_dw", 0, 1, 1, 0, O_DWAIT);
    step("md_last_go", 0, 0, 1, 0, O_NONE);
    step("md_last_new", 0, 0, 1, 0, O_MD);
    idle_cycle();

    // Redirect during a fetch wait, stale fetch returns two cycles later
    step("disc_redir", 1, 0, 0, 1, O_REDIR);
    step("disc_wait1", 1, 0, 0, 0, O_IWAIT);
    step("disc_wait2", 1, 0, 0, 0, O_IWAIT);
    step("disc_drop", 0, 0, 0, 0, O_DISC);
    step("disc_idle", 0, 0, 0, 0, O_NONE);

    // Stale fetch returns immediately: DISCARD lasts one cycle
    step("disc1_redir", 1, 0, 0, 1, O_REDIR);
    step("disc1_drop", 0, 0, 0, 0, O_DISC);
    step("disc1_idle", 0, 0, 0, 0, O_NONE);

    // Asynchronous reset mid-mul/div at cnt = 2
    step("rst_md_c1", 0, 0, 1, 0, O_MD);
    step("rst_md_c2", 0, 0, 1, 0, O_MD);
    step("rst_md_c3", 0, 0, 1, 0, O_MD);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", outs(), O_RESET);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_restart_c1", outs(), O_MD);
    step("rst_restart_c2", 0, 0, 1, 0, O_MD);
    step("rst_restart_c3", 0, 0, 1, 0, O_MD);
    step("rst_restart_c4", 0, 0, 1, 0, O_NONE);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_unit
